// File: rtl/lightshow_pkg.sv
// Shared types and widths for the light-show audio front end.
package lightshow_pkg;

    localparam int SAMPLE_W = 12;
    localparam int POWER_W  = 8;

    typedef enum logic [1:0] {
        WARMUP,
        ARMED,
        LOCKOUT
    } beat_state_t;

    // Magnitude of a two's-complement sample as an unsigned value.
    // -2048 wraps to 12'h800, which reads as 2048 unsigned.
    function automatic logic [SAMPLE_W-1:0] sample_mag(input logic [SAMPLE_W-1:0] s);
        return s[SAMPLE_W-1] ? SAMPLE_W'(-s) : s;
    endfunction

endpackage

// File: rtl/energy_history.sv
// Ring buffer of recent window means with a running sum, so the history
// average is a shift rather than a multi-operand add.
module energy_history
    import lightshow_pkg::*;
#(
    parameter int HIST_LOG2 = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [SAMPLE_W-1:0] mean,
    output logic [SAMPLE_W-1:0] avg,
    output logic                full
);

    localparam int DEPTH = 1 << HIST_LOG2;
    localparam int SUM_W = SAMPLE_W + HIST_LOG2;

    logic [SAMPLE_W-1:0]  ring [DEPTH];
    logic [HIST_LOG2-1:0] ptr;
    logic [SUM_W-1:0]     sum;
    logic [HIST_LOG2:0]   fill;

    // Replace the oldest entry, keep the sum consistent and count up to full.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the entries are cleared explicitly because the running sum
            // subtracts the oldest entry, which must be zero during warm-up.
            for (int i = 0; i < DEPTH; i++) begin
                ring[i] <= '0;
            end
            ptr  <= '0;
            sum  <= '0;
            fill <= '0;
        end else if (push) begin
            // NOTE: non-blocking assignments, so the subtraction below reads
            // the entry being overwritten, not the new mean.
            ring[ptr] <= mean;
            sum       <= sum + SUM_W'(mean) - SUM_W'(ring[ptr]);
            ptr       <= ptr + 1'b1;
            if (!fill[HIST_LOG2]) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Fill saturates at DEPTH, which is exactly the top bit of the counter.
    assign full = fill[HIST_LOG2];
    assign avg  = sum[SUM_W-1 -: SAMPLE_W];

endmodule

// File: rtl/beat_detector.sv
// Windowed mean-absolute energy, brightness output and beat detection with a
// post-beat lockout so downstream flash holds never overlap.
module beat_detector
    import lightshow_pkg::*;
#(
    parameter int             WINDOW_LOG2    = 10,
    parameter int             HIST_LOG2      = 3,
    parameter logic [3:0]     THRESH         = 4'd12,
    parameter logic [11:0]    MIN_ENERGY     = 12'd16,
    parameter int             LOCKOUT_CYCLES = 4_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sampleValid,
    output logic [POWER_W-1:0]  sigPower,
    output logic                isBeat
);

    localparam int ACC_W  = SAMPLE_W + WINDOW_LOG2;
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    logic [ACC_W-1:0]       acc;
    logic [WINDOW_LOG2-1:0] count;
    logic [SAMPLE_W-1:0]    mag;
    logic [ACC_W-1:0]       acc_sum;
    logic [SAMPLE_W-1:0]    mean;
    logic                   close;
    logic [SAMPLE_W-1:0]    avg;
    logic                   full;
    logic [15:0]            scaled_mean;
    logic [15:0]            scaled_avg;
    logic                   beat;
    beat_state_t            state;
    logic [LOCK_W-1:0]      lockout;

    assign mag     = sample_mag(sample);
    assign acc_sum = acc + ACC_W'(mag);
    assign mean    = acc_sum[ACC_W-1 -: SAMPLE_W];
    assign close   = sampleValid && (count == '1);

    // Both sides of the ratio test fit in 16 bits: 4095*8 and 4095*15.
    assign scaled_mean = {1'b0, mean, 3'b000};
    assign scaled_avg  = 16'(avg) * 16'(THRESH);

    // The avg seen here is the pre-insertion value because the history
    // only absorbs this window's mean on the same clock edge.
    assign beat = close && (state == ARMED) && (mean > MIN_ENERGY)
                  && (scaled_mean > scaled_avg);

    energy_history #(
        .HIST_LOG2(HIST_LOG2)
    ) u_history (
        .clk  (clk),
        .reset(reset),
        .push (close),
        .mean (mean),
        .avg  (avg),
        .full (full)
    );

    // Accumulate sample magnitudes; restart at each window close.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            count <= '0;
        end else if (sampleValid) begin
            acc   <= close ? '0 : acc_sum;
            count <= count + 1'b1;
        end
    end

    // Brightness from the closed window's mean, saturated to 8 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            sigPower <= '0;
        end else if (close) begin
            sigPower <= mean[SAMPLE_W-1] ? '1 : mean[10:3];
        end
    end

    // Warm-up, armed and lockout sequencing with the registered beat pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= WARMUP;
            lockout <= '0;
            isBeat  <= 1'b0;
        end else begin
            isBeat <= beat;
            case (state)
                WARMUP: begin
                    if (full) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (beat) begin
                        state   <= LOCKOUT;
                        lockout <= LOCK_W'(LOCKOUT_CYCLES - 1);
                    end
                end
                LOCKOUT: begin
                    if (lockout == '0) begin
                        state <= ARMED;
                    end else begin
                        lockout <= lockout - 1'b1;
                    end
                end
                default: begin
                    state <= WARMUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beat_detector.sv
// Randomised and directed bench for beat_detector against a window/queue model.
module tb_beat_detector;

    localparam int WINDOW_LOG2    = 2;
    localparam int HIST_LOG2      = 2;
    localparam int THRESH         = 12;
    localparam int MIN_ENERGY     = 16;
    localparam int LOCKOUT_CYCLES = 20;
    localparam int WIN            = 1 << WINDOW_LOG2;
    localparam int HIST           = 1 << HIST_LOG2;

    logic        clk;
    logic        reset;
    logic [11:0] sample;
    logic        sampleValid;
    logic [7:0]  sigPower;
    logic        isBeat;

    int n_checks;
    int n_fail;

    // Reference model state: samples of the open window, recent means,
    // windows since reset, and the edge number of the last beat.
    int part_q[$];
    int hist_q[$];
    int nwin;
    int last_beat;
    int cyc;
    int exp_power;
    int exp_beat;

    int last_close_beat;
    int last_close_power;

    beat_detector #(
        .WINDOW_LOG2   (WINDOW_LOG2),
        .HIST_LOG2     (HIST_LOG2),
        .THRESH        (4'(THRESH)),
        .MIN_ENERGY    (12'(MIN_ENERGY)),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sample     (sample),
        .sampleValid(sampleValid),
        .sigPower   (sigPower),
        .isBeat     (isBeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input int s);
        int total;
        int mean;
        int hsum;
        int avg;
        cyc++;
        if (r) begin
            part_q.delete();
            hist_q.delete();
            nwin      = 0;
            last_beat = -1000;
            exp_power = 0;
            exp_beat  = 0;
        end else begin
            exp_beat = 0;
            if (v) begin
                part_q.push_back(s < 0 ? -s : s);
                if (part_q.size() == WIN) begin
                    total = 0;
                    foreach (part_q[i]) total += part_q[i];
                    mean = total / WIN;
                    hsum = 0;
                    foreach (hist_q[i]) hsum += hist_q[i];
                    avg = hsum / HIST;
                    if (nwin >= HIST && mean > MIN_ENERGY && mean * 8 > avg * THRESH
                        && cyc - last_beat > LOCKOUT_CYCLES) begin
                        exp_beat  = 1;
                        last_beat = cyc;
                    end
                    hist_q.push_back(mean);
                    if (hist_q.size() > HIST) void'(hist_q.pop_front());
                    nwin++;
                    exp_power = (mean / 8 > 255) ? 255 : mean / 8;
                    part_q.delete();
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, observe just after the rising edge.
    task automatic step(input logic r, input logic v, input int s);
        @(negedge clk);
        reset       = r;
        sampleValid = v;
        sample      = 12'(s);
        @(posedge clk);
        #1;
        model_edge(r, v, s);
        check("sigPower", int'(sigPower), exp_power);
        check("isBeat", int'(isBeat), exp_beat);
    endtask

    task automatic window(input int value, input int pre_idle);
        for (int i = 0; i < pre_idle; i++) step(1'b0, 1'b0, 0);
        for (int i = 0; i < WIN; i++) step(1'b0, 1'b1, value);
        last_close_beat  = int'(isBeat);
        last_close_power = int'(sigPower);
    endtask

    task automatic warm_then(input int quiet, input int prior, input int loud);
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < prior; i++) window(quiet, 0);
        window(loud, 0);
    endtask

    initial begin
        int amp;
        logic r;
        logic v;
        int s;

        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        nwin        = 0;
        last_beat   = -1000;
        exp_power   = 0;
        exp_beat    = 0;
        reset       = 1'b1;
        sampleValid = 1'b0;
        sample      = '0;

        // Reset held with sampleValid high: outputs stay zero, nothing counted.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1000);
        check("reset_power", int'(sigPower), 0);

        // Power and saturation.
        window(-800, 0);
        check("power_800", last_close_power, 100);
        window(-2048, 0);
        check("power_sat", last_close_power, 255);

        // Warm-up: fifth window may beat, fourth may not.
        warm_then(100, 4, 800);
        check("warm_beat5", last_close_beat, 1);
        warm_then(100, 3, 800);
        check("warm_nobeat4", last_close_beat, 0);

        // Lockout: close 10 cycles after a beat is suppressed, 25 is not.
        warm_then(100, 4, 800);
        check("lock_ref_beat", last_close_beat, 1);
        window(2000, 6);
        check("lock_10", last_close_beat, 0);
        warm_then(100, 4, 800);
        check("lock_ref_beat2", last_close_beat, 1);
        window(2000, 21);
        check("lock_25", last_close_beat, 1);

        // Silence floor, then just above it.
        warm_then(2, 4, 15);
        check("floor_15", last_close_beat, 0);
        window(17, 0);
        check("floor_17", last_close_beat, 1);

        // Mid-window reset discards the partial window.
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1000);
        step(1'b0, 1'b1, 1000);
        step(1'b1, 1'b1, 1000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 400);
        check("midrst_noclose", int'(sigPower), 0);
        step(1'b0, 1'b1, 400);
        check("midrst_power", int'(sigPower), 50);

        // Random traffic with changing loudness to provoke beats and lockouts.
        amp = 50;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15) == 0) begin
                case ($urandom_range(3))
                    0: amp = 10;
                    1: amp = 150;
                    2: amp = 800;
                    default: amp = 2048;
                endcase
            end
            r = ($urandom_range(599) == 0);
            v = ($urandom_range(9) < 7);
            s = int'($urandom_range(2 * amp)) - amp;
            if (s > 2047) s = 2047;
            step(r, v, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
